// File: rtl/toggle_port_responder_pkg.sv
// Shared types and constants for the toggle-handshake memory port responder.
package toggle_port_responder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_CMD    = 2'd1;
  localparam state_t ST_RDWAIT = 2'd2;
  localparam state_t ST_DONE   = 2'd3;

  // Read-timeout fill value, sliced to the data width by the user.
  localparam logic [255:0] FILL_ONES = '1;

endpackage

// File: rtl/toggle_port_responder.sv
// Responder side of a req/ack toggle memory port: one single-beat access per
// request on a valid/ready back-end, read data returned before ack toggles.
//
// state  | meaning
// IDLE   | waiting for port_req != port_ack, latches the request
// CMD    | presenting the latched command until mem_ready
// RDWAIT | waiting for mem_rvalid or the timeout
// DONE   | toggling port_ack
module toggle_port_responder
  import toggle_port_responder_pkg::*;
#(
  parameter int AW      = 23,
  parameter int DW      = 16,
  parameter int TIMEOUT = 1023
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            port_req,
  output logic            port_ack,
  input  logic [AW-1:0]   port_a,
  input  logic [DW/8-1:0] port_ds,
  input  logic            port_we,
  input  logic [DW-1:0]   port_d,
  output logic [DW-1:0]   port_q,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW/8-1:0] mem_be,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy,
  output logic            err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

  state_t        state;
  logic [CW-1:0] cnt;

  assign mem_valid = (state == ST_CMD);
  assign busy      = (state != ST_IDLE);

  // The mem_* command registers double as the latched copy of the request.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      port_ack  <= 1'b0;
      port_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (port_req != port_ack) begin
            mem_we    <= port_we;
            mem_addr  <= port_a;
            mem_be    <= port_ds;
            mem_wdata <= port_d;
            if (port_we && (port_ds == '0)) state <= ST_DONE;
            else                            state <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (mem_ready) begin
            if (mem_we) begin
              state <= ST_DONE;
            end else begin
              state <= ST_RDWAIT;
              cnt   <= '0;
            end
          end
        end
        ST_RDWAIT: begin
          if (mem_rvalid) begin
            port_q <= mem_rdata;
            state  <= ST_DONE;
          end else if (cnt == TIMEOUT_CNT) begin
            port_q <= FILL_ONES[DW-1:0];
            err    <= 1'b1;
            state  <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          port_ack <= ~port_ack;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/toggle_port_responder.md
# toggle_port_responder

Responder end of the toggle-handshake memory port that the ROM download controller and the CPU ROM paths drive (port_req / port_ack, address, byte strobes, write enable, data). It detects a new request by comparing the req toggle with its own ack toggle and performs one single-beat access on a simple valid/ready memory back-end. It then returns read data and toggles ack. It sits between the requesting logic and an SDRAM or BRAM controller.

## Interface
Parameters:
- AW, 23: word address width.
- DW, 16: data width; byte strobes are DW/8 wide.
- TIMEOUT, 1023: maximum cycles to wait for read data before forcing completion.

Ports:
- clk_sys  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- port_req  in  1  request toggle; a new request is pending when port_req != port_ack.
- port_ack  out  1  acknowledge toggle.
- port_a  in  AW  word address.
- port_ds  in  DW/8  byte strobes; bit i enables byte i.
- port_we  in  1  1 = write, 0 = read.
- port_d  in  DW  write data.
- port_q  out  DW  read data.
- mem_valid  out  1  command valid.
- mem_ready  in  1  command accepted when valid && ready.
- mem_we, mem_addr[AW], mem_be[DW/8], mem_wdata[DW]  out  command fields.
- mem_rvalid  in  1  read data strobe.
- mem_rdata  in  DW  read data.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle pulse when a read times out.

## Operation
- The requester is in the clk_sys domain. No synchronizer is used on port_req.
- States: IDLE, CMD, RDWAIT, DONE.
- IDLE, port_req != port_ack: latch port_a, port_ds, port_we, port_d.
  - Write with port_ds == 0: go to DONE. No memory command is issued.
  - Otherwise: go to CMD.
- CMD: mem_valid = 1. All command fields come from the latched copy and stay stable until accepted.
  - On mem_valid && mem_ready: a write goes to DONE; a read goes to RDWAIT and clears the timeout counter.
- RDWAIT:
  - On mem_rvalid: port_q <= mem_rdata, go to DONE.
  - Else if the counter == TIMEOUT: port_q <= all ones, err pulses, go to DONE.
  - Else: counter increments.
- DONE: port_ack <= ~port_ack, go to IDLE.
- Reads always fetch the full word. port_ds is forwarded as mem_be but does not mask port_q.
- port_q holds its value until the next completed read. Writes never change port_q.
- mem_rvalid outside RDWAIT is ignored.
- A port_req toggle while busy is not lost. It is sampled when the block returns to IDLE, because the condition is a level (req != ack).
- Input changes after the IDLE latch cycle have no effect on the current transaction.

## Timing
- Reset values: port_ack = 0, port_q = 0, mem_valid = 0, mem_we/mem_addr/mem_be/mem_wdata = 0, busy = 0, err = 0, state = IDLE, counter = 0.
- Reset in the middle of a transaction: the block returns to IDLE next edge and mem_valid drops immediately. The requester must also reset its req to 0 so the toggles stay aligned.
- Write latency, request seen in IDLE at cycle 0:
  - mem_valid is high from cycle 1.
  - If mem_ready is high at cycle 1, port_ack toggles at the cycle 3 edge (IDLE→CMD→DONE→IDLE).
  - Each cycle mem_ready is held low adds one cycle.
- ds == 0 write: port_ack toggles 2 cycles after IDLE detection.
- Read latency: port_ack toggles one cycle after the DONE entry that follows mem_rvalid. port_q is valid no later than the edge where port_ack toggles.
- Timeout: err pulses for the single cycle in DONE. The counter is AW-independent and sized to clog2(TIMEOUT+1).
- Back-to-back: the minimum spacing between acks is 3 cycles for writes and 4 cycles for reads with a zero-latency memory.

## Structure
- A shared package holds the state enum (IDLE, CMD, RDWAIT, DONE) and the all-ones timeout fill constant.
- The block is a single module. No sub-module is needed; the latch, FSM and timeout counter all live in the one file.

## Test plan
- Write: toggle req with a=0x000123, ds=2'b01, we=1, d=0xA55A, mem_ready=1 -> one command with mem_addr=0x000123, mem_be=01, mem_wdata=0xA55A; ack toggles 3 cycles after detection.
- Read with 5-cycle memory latency: mem_rdata=0xBEEF -> port_q=0xBEEF and ack toggles; err stays 0.
- Backpressure: mem_ready held low for 7 cycles -> mem_valid and all command fields are stable throughout; exactly one accept.
- ds == 0 write -> mem_valid never asserts and ack toggles after 2 cycles.
- Read with no mem_rvalid -> after TIMEOUT+1 RDWAIT cycles, port_q=0xFFFF, one err pulse, ack toggles; a later mem_rvalid is ignored.
- Reset during CMD -> next cycle mem_valid=0, port_ack=0, busy=0. Then a req toggle (0→1) is serviced normally. Separately, 256 random back-to-back writes each produce exactly one ack.
